// File: rtl/fetch_unit_pkg.sv
// Shared types and constants for the instruction-fetch stage.
package fetch_unit_pkg;

  localparam int unsigned WORD_WIDTH  = 32;
  localparam int unsigned INSTR_BYTES = 4;
  localparam int unsigned FETCH_DEPTH = 2;

  typedef enum logic {
    ST_RUN   = 1'b0,
    ST_FLUSH = 1'b1
  } fetch_state_e;

  typedef struct packed {
    logic [WORD_WIDTH-1:0] pc;
    logic [WORD_WIDTH-1:0] instr;
  } fetch_entry_t;

endpackage

// File: rtl/fetch_unit_if.sv
// Instruction-memory request/response and decode handshake bundle of the fetch stage.
interface fetch_unit_if;
  import fetch_unit_pkg::*;

  logic                  imem_req_valid;
  logic                  imem_req_ready;
  logic [WORD_WIDTH-1:0] imem_req_addr;
  logic                  imem_rsp_valid;
  logic [WORD_WIDTH-1:0] imem_rsp_data;
  logic                  id_valid;
  logic                  id_ready;
  logic [WORD_WIDTH-1:0] id_pc;
  logic [WORD_WIDTH-1:0] id_instr;

  modport master (
    output imem_req_valid, imem_req_addr, id_valid, id_pc, id_instr,
    input  imem_req_ready, imem_rsp_valid, imem_rsp_data, id_ready
  );

  modport slave (
    input  imem_req_valid, imem_req_addr, id_valid, id_pc, id_instr,
    output imem_req_ready, imem_rsp_valid, imem_rsp_data, id_ready
  );
endinterface

// File: rtl/fetch_queue.sv
// Synchronous FIFO with clear; head word comes straight from registered storage.
module fetch_queue #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned DEPTH = 2
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         i_clear,
  input  logic                         i_push,
  input  logic                         i_pop,
  input  logic [WIDTH-1:0]             i_data,
  output logic [WIDTH-1:0]             o_data,
  output logic [$clog2(DEPTH):0]       o_count,
  output logic                         o_full,
  output logic                         o_empty
);

  localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CW = $clog2(DEPTH) + 1;

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wptr;
  logic [AW-1:0]    r_rptr;
  logic [CW-1:0]    r_count;

  // Clear wins over push/pop; callers never pop an empty queue.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < DEPTH; i++) r_mem[i] <= '0;
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else if (i_clear) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else begin
      if (i_push) begin
        r_mem[r_wptr] <= i_data;
        r_wptr        <= r_wptr + AW'(1);
      end
      if (i_pop) r_rptr <= r_rptr + AW'(1);
      r_count <= r_count + CW'(i_push) - CW'(i_pop);
    end
  end

  assign o_data  = r_mem[r_rptr];
  assign o_count = r_count;
  assign o_full  = (r_count == CW'(DEPTH));
  assign o_empty = (r_count == '0);

endmodule

// File: rtl/fetch_unit.sv
// Fetch stage: credit-limited in-order imem requests, prefetch queue, redirect flush.
// Optional build macro FETCH_PERF_EN adds perf_fetched / perf_dropped counters.
module fetch_unit
  import fetch_unit_pkg::*;
#(
  parameter int unsigned DEPTH = FETCH_DEPTH
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [WORD_WIDTH-1:0] pc,
  output logic [WORD_WIDTH-1:0] pc_in,
  output logic                  freeze,
  input  logic                  redirect_valid,
  input  logic [WORD_WIDTH-1:0] redirect_target,
  fetch_unit_if.master          fif
`ifdef FETCH_PERF_EN
  ,
  output logic [31:0]           perf_fetched,
  output logic [31:0]           perf_dropped
`endif
);

  localparam int unsigned CW = $clog2(DEPTH) + 1;
  localparam int unsigned EW = $bits(fetch_entry_t);

  fetch_state_e          r_state;
  fetch_state_e          w_state_nxt;
  logic [CW-1:0]         r_drop;
  logic [CW-1:0]         w_drop_nxt;

  logic [CW-1:0]         w_pend_count;
  logic [CW-1:0]         w_q_count;
  logic [CW:0]           w_used;
  logic                  w_pend_full;
  logic                  w_pend_empty;
  logic                  w_q_full;
  logic                  w_q_empty;
  logic [WORD_WIDTH-1:0] w_pend_head;
  logic [EW-1:0]         w_q_rdata;
  fetch_entry_t          w_q_head;
  fetch_entry_t          w_q_wdata;

  logic                  w_credit;
  logic                  w_rsp_live;
  logic                  w_req_valid;
  logic                  w_issue;
  logic                  w_rsp_acc;
  logic                  w_rsp_drop;
  logic                  w_clear;
  logic                  w_id_pop;

  assign w_used     = {1'b0, w_pend_count} + {1'b0, w_q_count};
  assign w_credit   = !w_pend_full && !w_q_full && (w_used < (CW+1)'(DEPTH));
  assign w_rsp_live = fif.imem_rsp_valid && !w_pend_empty;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_RUN;
      r_drop  <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_drop  <= w_drop_nxt;
    end
  end

  // Next state, PC control and queue strobes; reset forces a held PC and no requests.
  always_comb begin
    w_state_nxt = r_state;
    w_drop_nxt  = r_drop;
    w_req_valid = 1'b0;
    w_issue     = 1'b0;
    w_rsp_acc   = 1'b0;
    w_rsp_drop  = 1'b0;
    w_clear     = 1'b0;
    pc_in       = pc;
    freeze      = 1'b1;
    if (rst_n) begin
      case (r_state)
        ST_RUN: begin
          if (redirect_valid) begin
            w_clear    = 1'b1;
            pc_in      = redirect_target;
            freeze     = 1'b0;
            w_rsp_drop = w_rsp_live;
            w_drop_nxt = w_pend_count - CW'(w_rsp_live);
            if (w_drop_nxt != '0) w_state_nxt = ST_FLUSH;
          end else begin
            w_req_valid = w_credit;
            w_issue     = w_credit && fif.imem_req_ready;
            w_rsp_acc   = w_rsp_live;
            if (w_issue) begin
              pc_in  = pc + WORD_WIDTH'(INSTR_BYTES);
              freeze = 1'b0;
            end
          end
        end
        ST_FLUSH: begin
          if (fif.imem_rsp_valid && (r_drop != '0)) begin
            w_rsp_drop = 1'b1;
            w_drop_nxt = r_drop - CW'(1);
            if (r_drop == CW'(1)) w_state_nxt = ST_RUN;
          end
          if (redirect_valid) begin
            w_clear = 1'b1;
            pc_in   = redirect_target;
            freeze  = 1'b0;
          end
        end
        default: w_state_nxt = ST_RUN;
      endcase
    end
  end

  assign w_id_pop  = fif.id_valid && fif.id_ready && !w_clear;
  assign w_q_wdata = '{pc: w_pend_head, instr: fif.imem_rsp_data};
  assign w_q_head  = fetch_entry_t'(w_q_rdata);

  fetch_queue #(.WIDTH(WORD_WIDTH), .DEPTH(DEPTH)) u_pend_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_clear (w_clear),
    .i_push  (w_issue),
    .i_pop   (w_rsp_acc),
    .i_data  (pc),
    .o_data  (w_pend_head),
    .o_count (w_pend_count),
    .o_full  (w_pend_full),
    .o_empty (w_pend_empty)
  );

  fetch_queue #(.WIDTH(EW), .DEPTH(DEPTH)) u_instr_q (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_clear (w_clear),
    .i_push  (w_rsp_acc),
    .i_pop   (w_id_pop),
    .i_data  (w_q_wdata),
    .o_data  (w_q_rdata),
    .o_count (w_q_count),
    .o_full  (w_q_full),
    .o_empty (w_q_empty)
  );

  assign fif.imem_req_valid = w_req_valid;
  assign fif.imem_req_addr  = pc;
  assign fif.id_valid       = !w_q_empty;
  assign fif.id_pc          = w_q_head.pc;
  assign fif.id_instr       = w_q_head.instr;

`ifdef FETCH_PERF_EN
  logic [31:0] r_perf_fetched;
  logic [31:0] r_perf_dropped;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_perf_fetched <= '0;
      r_perf_dropped <= '0;
    end else begin
      if (w_id_pop)   r_perf_fetched <= r_perf_fetched + 32'd1;
      if (w_rsp_drop) r_perf_dropped <= r_perf_dropped + 32'd1;
    end
  end

  assign perf_fetched = r_perf_fetched;
  assign perf_dropped = r_perf_dropped;
`endif

endmodule

// File: tb/tb_fetch_unit.sv
// Randomized self-checking bench for fetch_unit against a queue-based reference model.
module tb_fetch_unit;

  localparam int unsigned DEPTH = 2;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] instr;
  } exp_entry_t;

  typedef struct {
    logic [31:0] addr;
    int unsigned cyc;
  } mem_req_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [31:0] pc = 32'h0;
  logic [31:0] pc_in;
  logic        freeze;
  logic        redirect_valid = 1'b0;
  logic [31:0] redirect_target = 32'h0;
`ifdef FETCH_PERF_EN
  logic [31:0] perf_fetched;
  logic [31:0] perf_dropped;
`endif

  fetch_unit_if bus ();

  fetch_unit #(.DEPTH(DEPTH)) dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .pc              (pc),
    .pc_in           (pc_in),
    .freeze          (freeze),
    .redirect_valid  (redirect_valid),
    .redirect_target (redirect_target),
    .fif             (bus)
`ifdef FETCH_PERF_EN
    ,
    .perf_fetched    (perf_fetched),
    .perf_dropped    (perf_dropped)
`endif
  );

  always #5 clk = ~clk;

  int unsigned cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Reference model state
  exp_entry_t  exp_q[$];
  mem_req_t    mem_q[$];
  int          n_live = 0;
  int          n_drop = 0;
  int unsigned n_fetched = 0;
  int unsigned n_dropped = 0;

  int n_err = 0;
  int n_chk = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h expected 0x%08h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic logic [31:0] memfn(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h5A5A_1234;
  endfunction

  task automatic check_perf();
`ifdef FETCH_PERF_EN
    check("perf_fetched", perf_fetched, n_fetched);
    check("perf_dropped", perf_dropped, n_dropped);
`endif
  endtask

  // One clock cycle: drive, check outputs against the model, advance the model and the PC register.
  task automatic step(input logic redir, input logic [31:0] tgt, input logic rdy,
                      input logic idr, input logic rsp_en);
    logic        exp_req, issue, rsp, exp_frz;
    logic [31:0] exp_pcin;
    exp_entry_t  e;
    mem_req_t    m;
    @(negedge clk);
    redirect_valid     = redir;
    redirect_target    = tgt;
    bus.imem_req_ready = rdy;
    bus.id_ready       = idr;
    rsp = rsp_en && (mem_q.size() != 0) && (mem_q[0].cyc < cyc);
    bus.imem_rsp_valid = rsp;
    bus.imem_rsp_data  = rsp ? memfn(mem_q[0].addr) : $urandom;
    #1;
    exp_req  = !redir && (n_drop == 0) && ((n_live + exp_q.size()) < DEPTH);
    issue    = exp_req && rdy;
    exp_pcin = redir ? tgt : (issue ? pc + 32'd4 : pc);
    exp_frz  = !(redir || issue);
    check("imem_req_valid", {31'b0, bus.imem_req_valid}, {31'b0, exp_req});
    check("imem_req_addr", bus.imem_req_addr, pc);
    check("pc_in", pc_in, exp_pcin);
    check("freeze", {31'b0, freeze}, {31'b0, exp_frz});
    check("id_valid", {31'b0, bus.id_valid}, {31'b0, exp_q.size() != 0});
    if (exp_q.size() != 0) begin
      check("id_pc", bus.id_pc, exp_q[0].pc);
      check("id_instr", bus.id_instr, exp_q[0].instr);
    end
    check_perf();

    if ((exp_q.size() != 0) && idr && !redir) begin
      void'(exp_q.pop_front());
      n_fetched++;
    end
    if (rsp) begin
      m = mem_q.pop_front();
      if (n_drop > 0) begin
        n_drop--;
        n_dropped++;
      end else if (n_live > 0) begin
        n_live--;
        if (redir) n_dropped++;
        else begin
          e.pc    = m.addr;
          e.instr = memfn(m.addr);
          exp_q.push_back(e);
        end
      end
    end
    if (redir) begin
      n_drop += n_live;
      n_live  = 0;
      exp_q.delete();
    end
    if (issue) begin
      n_live++;
      m.addr = pc;
      m.cyc  = cyc;
      mem_q.push_back(m);
    end
    @(posedge clk);
    #1;
    if (!exp_frz) pc = exp_pcin;
  endtask

  // Assert reset for a few cycles; the memory keeps its in-flight requests as stale.
  task automatic do_reset(input int cycles);
    @(negedge clk);
    rst_n              = 1'b0;
    redirect_valid     = 1'b0;
    bus.imem_req_ready = 1'b0;
    bus.imem_rsp_valid = 1'b0;
    bus.id_ready       = 1'b0;
    #1;
    n_live = 0;
    n_drop = 0;
    n_fetched = 0;
    n_dropped = 0;
    exp_q.delete();
    check("rst id_valid", {31'b0, bus.id_valid}, 32'd0);
    check("rst req_valid", {31'b0, bus.imem_req_valid}, 32'd0);
    check("rst freeze", {31'b0, freeze}, 32'd1);
    check("rst pc_in", pc_in, pc);
    repeat (cycles) @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    bus.imem_req_ready = 1'b0;
    bus.imem_rsp_valid = 1'b0;
    bus.imem_rsp_data  = 32'h0;
    bus.id_ready       = 1'b0;

    // Reset values
    #1;
    check("rst id_pc", bus.id_pc, 32'h0);
    check("rst id_instr", bus.id_instr, 32'h0);
    do_reset(2);

    // Sequential fetch from 0x0 with 1-cycle memory
    repeat (12) step(1'b0, 32'h0, 1'b1, 1'b1, 1'b1);

    // Decode stalled: credit limits outstanding work to DEPTH, then release
    repeat (8) step(1'b0, 32'h0, 1'b1, 1'b0, 1'b1);
    repeat (6) step(1'b0, 32'h0, 1'b1, 1'b1, 1'b1);

    // Redirect to 0x100 with two requests in flight
    repeat (3) step(1'b0, 32'h0, 1'b1, 1'b1, 1'b0);
    step(1'b1, 32'h100, 1'b1, 1'b1, 1'b0);
    check("flush drop count", n_drop, 32'd2);
    repeat (10) step(1'b0, 32'h0, 1'b1, 1'b1, 1'b1);

    // PC wrap-around at the top of the address space
    step(1'b1, 32'hFFFF_FFF8, 1'b1, 1'b1, 1'b1);
    repeat (12) step(1'b0, 32'h0, 1'b1, 1'b1, 1'b1);

    // Random traffic: ready toggling, random decode stalls and redirects
    for (int i = 0; i < 3000; i++) begin
      logic redir, rdy;
      redir = ($urandom_range(0, 24) == 0);
      rdy   = (i < 1500) ? logic'(i % 2) : logic'($urandom_range(0, 1));
      step(redir, $urandom & 32'hFFFF_FFFC, rdy, logic'($urandom_range(0, 1)),
           ($urandom_range(0, 3) != 0));
    end

    // Drain, then reset while flushing with one response outstanding
    repeat (8) step(1'b0, 32'h0, 1'b0, 1'b1, 1'b1);
    step(1'b0, 32'h0, 1'b1, 1'b1, 1'b0);
    step(1'b1, 32'h200, 1'b0, 1'b1, 1'b0);
    check("flush drop one", n_drop, 32'd1);
    step(1'b0, 32'h0, 1'b0, 1'b1, 1'b0);
    do_reset(2);
    step(1'b0, 32'h0, 1'b0, 1'b1, 1'b1);
    check("stale rsp drained", mem_q.size(), 32'd0);
    step(1'b0, 32'h0, 1'b0, 1'b1, 1'b1);
    repeat (10) step(1'b0, 32'h0, 1'b1, 1'b1, 1'b1);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
